// File: rtl/mem_port_initiator.sv
// Load/store initiator for a single-port synchronous RAM: byte/half/word access, one transaction in flight.
// Define MEM_MISALIGN_TRAP_EN to reject misaligned/reserved requests with rsp_err instead of coercing them.
module mem_port_initiator #(
    parameter int ADDR_WIDTH = 11,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  nrst,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [ADDR_WIDTH+1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_rdata,
    output logic                  rsp_err,
    output logic                  ram_en,
    output logic [3:0]            ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [DATA_WIDTH-1:0] ram_din,
    input  logic [DATA_WIDTH-1:0] ram_dout
);

    typedef enum logic [1:0] {IDLE, RD_CAP, RESP} state_t;

    state_t                state, stateNxt;
    logic                  accept, trap;
    logic [1:0]            effSize, effOff;
    logic [3:0]            weMask;
    logic [DATA_WIDTH-1:0] dinRep;
    logic [1:0]            capSize, capOff;
    logic                  capUns;
    logic [DATA_WIDTH-1:0] rdShift, rdExt, rdataQ;
    logic                  errQ;

    assign req_ready = nrst && (state == IDLE);
    assign accept    = req_valid && req_ready;
    assign rsp_valid = (state == RESP);
    assign rsp_rdata = rdataQ;
    assign rsp_err   = errQ;

`ifdef MEM_MISALIGN_TRAP_EN
    assign trap = (req_size == 2'b11) ||
                  (req_size == 2'b01 && req_addr[0]) ||
                  (req_size == 2'b10 && req_addr[1:0] != 2'b00);
`else
    assign trap = 1'b0;
`endif

    // Coerced size/offset; identical to the raw request whenever it is aligned.
    always_comb begin
        effSize = (req_size == 2'b11) ? 2'b10 : req_size;
        case (effSize)
            2'b00:   begin effOff = req_addr[1:0];        weMask = 4'b0001 << req_addr[1:0];
                           dinRep = {4{req_wdata[7:0]}}; end
            2'b01:   begin effOff = {req_addr[1], 1'b0};  weMask = req_addr[1] ? 4'b1100 : 4'b0011;
                           dinRep = {2{req_wdata[15:0]}}; end
            default: begin effOff = 2'b00;                weMask = 4'b1111;
                           dinRep = req_wdata; end
        endcase
    end

    always_comb begin
        ram_en   = accept && !trap;
        ram_addr = ram_en ? req_addr[ADDR_WIDTH+1:2] : '0;
        ram_we   = (ram_en && req_we) ? weMask : 4'b0000;
        ram_din  = (ram_en && req_we) ? dinRep : '0;
    end

    always_comb begin
        stateNxt = state;
        case (state)
            IDLE:    if (accept) stateNxt = (trap || req_we) ? RESP : RD_CAP;
            RD_CAP:  stateNxt = RESP;
            RESP:    if (rsp_ready) stateNxt = IDLE;
            default: stateNxt = IDLE;
        endcase
    end

    always_comb begin
        rdShift = ram_dout >> {capOff, 3'b000};
        case (capSize)
            2'b00:   rdExt = capUns ? {24'h0, rdShift[7:0]}  : {{24{rdShift[7]}}, rdShift[7:0]};
            2'b01:   rdExt = capUns ? {16'h0, rdShift[15:0]} : {{16{rdShift[15]}}, rdShift[15:0]};
            default: rdExt = ram_dout;
        endcase
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state   <= IDLE;
            capSize <= 2'b00;
            capOff  <= 2'b00;
            capUns  <= 1'b0;
            rdataQ  <= '0;
            errQ    <= 1'b0;
        end else begin
            state <= stateNxt;
            if (accept) begin
                capSize <= effSize;
                capOff  <= effOff;
                capUns  <= req_unsigned;
                rdataQ  <= '0;
                errQ    <= trap;
            end else if (state == RD_CAP) begin
                rdataQ <= rdExt;
            end
        end
    end

endmodule

// File: tb/tb_mem_port_initiator.sv
// Scoreboard bench for mem_port_initiator: behavioural RAM, shadow memory, directed and random loads/stores.
module tb_mem_port_initiator;
    localparam int AW = 11;
`ifdef MEM_MISALIGN_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic clk = 0, nrst = 0;
    logic req_valid = 0, req_ready, req_we = 0, req_unsigned = 0;
    logic [1:0] req_size = 0;
    logic [AW+1:0] req_addr = 0;
    logic [31:0] req_wdata = 0;
    logic rsp_valid, rsp_ready = 1, rsp_err;
    logic [31:0] rsp_rdata;
    logic ram_en;
    logic [3:0] ram_we;
    logic [AW-1:0] ram_addr;
    logic [31:0] ram_din, ram_dout = 0;

    mem_port_initiator #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) dut (
        .clk(clk), .nrst(nrst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_din(ram_din), .ram_dout(ram_dout)
    );

    always #5 clk = ~clk;

    typedef struct { logic [31:0] data; logic err; int lat; int acc; } exp_t;
    exp_t q[$];
    int total = 0, bad = 0, cyc = 0;
    logic [31:0] mem [0:(1<<AW)-1];
    logic [31:0] shadow [0:(1<<AW)-1];
    logic [3:0] lastWe;
    logic [31:0] lastDin;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s act=%h exp=%h t=%0t", tag, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Synchronous RAM, read-before-write
    always @(posedge clk) begin
        logic [31:0] w;
        if (ram_en) begin
            w = mem[ram_addr];
            ram_dout <= w;
            for (int i = 0; i < 4; i++) if (ram_we[i]) w[i*8 +: 8] = ram_din[i*8 +: 8];
            mem[ram_addr] <= w;
        end
    end

    always @(negedge clk) begin
        if (nrst && rsp_valid && rsp_ready) begin
            if (q.size() == 0) chk("spurious_rsp", {31'h0, rsp_valid}, 32'h0);
            else begin
                exp_t e;
                e = q.pop_front();
                chk("rdata", rsp_rdata, e.data);
                chk("err", {31'h0, rsp_err}, {31'h0, e.err});
                if (e.lat != 0) chk("latency", cyc - e.acc, e.lat);
            end
        end
    end

    function automatic bit misal(input logic [1:0] sz, input logic [AW+1:0] a);
        return (sz == 2'b11) || (sz == 2'b01 && a[0]) || (sz == 2'b10 && a[1:0] != 2'b00);
    endfunction

    function automatic logic [31:0] refLoad(input logic [31:0] w, input logic [1:0] sz,
                                            input logic uns, input logic [1:0] off);
        logic [7:0] b;
        logic [15:0] h;
        case (off)
            2'd0: b = w[7:0];
            2'd1: b = w[15:8];
            2'd2: b = w[23:16];
            default: b = w[31:24];
        endcase
        h = off[1] ? w[31:16] : w[15:0];
        case (sz)
            2'b00: return uns ? {24'h0, b} : {{24{b[7]}}, b};
            2'b01: return uns ? {16'h0, h} : {{16{h[15]}}, h};
            default: return w;
        endcase
    endfunction

    function automatic logic [3:0] refWe(input logic [1:0] sz, input logic [1:0] off);
        case (sz)
            2'b00: case (off) 2'd0: return 4'b0001; 2'd1: return 4'b0010;
                              2'd2: return 4'b0100; default: return 4'b1000; endcase
            2'b01: return off[1] ? 4'b1100 : 4'b0011;
            default: return 4'b1111;
        endcase
    endfunction

    function automatic logic [31:0] refDin(input logic [1:0] sz, input logic [31:0] d);
        case (sz)
            2'b00: return {d[7:0], d[7:0], d[7:0], d[7:0]};
            2'b01: return {d[15:0], d[15:0]};
            default: return d;
        endcase
    endfunction

    task automatic doReq(input logic we, input logic [1:0] sz, input logic uns,
                         input logic [AW+1:0] a, input logic [31:0] wd,
                         input logic [31:0] expData, input bit chkLat);
        bit mis, got;
        logic [3:0] m;
        logic [31:0] d;
        exp_t e;
        mis = TRAP && misal(sz, a);
        @(posedge clk); #1;
        req_valid = 1; req_we = we; req_size = sz; req_unsigned = uns; req_addr = a; req_wdata = wd;
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            got = req_ready;
        end
        if (!got) chk("accept_timeout", {31'h0, req_ready}, 32'h1);
        else begin
            lastWe = ram_we; lastDin = ram_din;
            chk("ram_en", {31'h0, ram_en}, {31'h0, !mis});
            if (!mis) chk("ram_addr", {21'h0, ram_addr}, {21'h0, a[AW+1:2]});
            if (we && !mis) begin
                m = refWe(sz == 2'b11 ? 2'b10 : sz, a[1:0]);
                d = refDin(sz == 2'b11 ? 2'b10 : sz, wd);
                chk("ram_we", {28'h0, ram_we}, {28'h0, m});
                chk("ram_din", ram_din, d);
                for (int i = 0; i < 4; i++) if (m[i]) shadow[a[AW+1:2]][i*8 +: 8] = d[i*8 +: 8];
            end else chk("ram_we_rd", {28'h0, ram_we}, 32'h0);
            e.data = (we || mis) ? 32'h0 : expData;
            e.err = mis;
            e.lat = chkLat ? ((we || mis) ? 1 : 2) : 0;
            e.acc = cyc;
            q.push_back(e);
        end
        @(posedge clk); #1;
        req_valid = 0;
        for (int n = 0; n < 40 && q.size() != 0; n++) @(negedge clk);
        if (q.size() != 0) begin
            chk("rsp_timeout", q.size(), 0);
            q.delete();
        end
    endtask

    initial begin
        logic [1:0] sz;
        logic [AW+1:0] a;
        logic we, uns;
        logic [31:0] wd;
        bit seen;
        for (int i = 0; i < (1 << AW); i++) begin mem[i] = 0; shadow[i] = 0; end
        mem[5] = 32'h80817F02; shadow[5] = 32'h80817F02;

        #2;
        chk("rst_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rst_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rst_ram_en", {31'h0, ram_en}, 32'h0);
        chk("rst_ram_we", {28'h0, ram_we}, 32'h0);
        chk("rst_rdata", rsp_rdata, 32'h0);
        #10 nrst = 1;
        @(negedge clk);
        chk("post_rst_ready", {31'h0, req_ready}, 32'h1);

        doReq(0, 2'b00, 0, 13'h17, 0, 32'hFFFFFF80, 1);
        doReq(0, 2'b01, 1, 13'h16, 0, 32'h00008081, 1);
        doReq(0, 2'b01, 0, 13'h14, 0, 32'h00007F02, 1);
        doReq(1, 2'b00, 0, 13'h15, 32'h000000AB, 0, 1);
        chk("sb_we", {28'h0, lastWe}, 32'h2);
        chk("sb_din", lastDin, 32'hABABABAB);
        doReq(0, 2'b10, 0, 13'h14, 0, 32'h8081AB02, 1);
        doReq(0, 2'b10, 0, 13'h15, 0, 32'h8081AB02, 1);
        doReq(0, 2'b11, 1, 13'h14, 0, 32'h8081AB02, 1);

        // Response held off for 3 cycles
        @(posedge clk); #1 rsp_ready = 0;
        fork
            doReq(0, 2'b01, 1, 13'h16, 0, 32'h00008081, 0);
            begin
                seen = 0;
                for (int n = 0; n < 20 && !seen; n++) begin @(negedge clk); seen = rsp_valid; end
                chk("stall_seen", {31'h0, seen}, 32'h1);
                for (int i = 0; i < 3; i++) begin
                    if (i > 0) @(negedge clk);
                    chk("stall_valid", {31'h0, rsp_valid}, 32'h1);
                    chk("stall_rdata", rsp_rdata, 32'h00008081);
                    chk("stall_ready", {31'h0, req_ready}, 32'h0);
                end
                @(posedge clk); #1 rsp_ready = 1;
            end
        join

        doReq(1, 2'b01, 0, 13'h16, 32'hFFFF1234, 0, 1);
        doReq(0, 2'b10, 0, 13'h14, 0, 32'h1234AB02, 1);
        doReq(1, 2'b10, 0, 13'h1FFC, 32'hDEADBEEF, 0, 1);
        doReq(0, 2'b00, 1, 13'h1FFF, 0, 32'h000000DE, 1);
        doReq(0, 2'b00, 0, 13'h1FFF, 0, 32'hFFFFFFDE, 1);
        doReq(0, 2'b01, 0, 13'h1FFE, 0, 32'hFFFFDEAD, 1);

        for (int k = 0; k < 24; k++) begin
            sz = 2'($urandom_range(0, 2));
            a = 13'($urandom_range(0, 31));
            if (sz == 2'b01) a[0] = 1'b0;
            if (sz == 2'b10) a[1:0] = 2'b00;
            we = 1'($urandom_range(0, 1));
            uns = 1'($urandom_range(0, 1));
            wd = $urandom;
            doReq(we, sz, uns, a, wd, refLoad(shadow[a[AW+1:2]], sz, uns, a[1:0]), 1);
        end

        // Reset while the load sits in RD_CAP
        @(posedge clk); #1;
        req_valid = 1; req_we = 0; req_size = 2'b00; req_unsigned = 0; req_addr = 13'h17;
        @(negedge clk);
        chk("rc_accept", {31'h0, req_ready}, 32'h1);
        @(posedge clk); #1;
        req_valid = 0;
        nrst = 0; #1;
        chk("rc_req_ready", {31'h0, req_ready}, 32'h0);
        chk("rc_rsp_valid", {31'h0, rsp_valid}, 32'h0);
        chk("rc_ram_en", {31'h0, ram_en}, 32'h0);
        chk("rc_rdata", rsp_rdata, 32'h0);
        #1 nrst = 1;
        @(negedge clk);
        chk("rc_post_ready", {31'h0, req_ready}, 32'h1);
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            chk("rc_no_rsp", {31'h0, rsp_valid}, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
